// File: rtl/thread_fetch_scheduler.sv
// Round-robin hardware-thread fetch scheduler: one PC and block bit per thread,
// picks one eligible thread per cycle and issues its PC/TID with one-cycle latency.

module thread_fetch_slot #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            thread_en,
    input  logic            block_set,
    input  logic            block_clr,
    input  logic            redirect_hit,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            advance,
    output logic [XLEN-1:0] pc,
    output logic            eligible
);
    logic blocked;

    // A redirect or a block request landing this cycle must keep the thread
    // out of selection so a stale PC is never issued.
    assign eligible = thread_en & ~blocked & ~block_set & ~redirect_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            blocked <= 1'b0;
        end else begin
            if (redirect_hit)
                pc <= redirect_pc;
            else if (advance)
                pc <= pc + XLEN'(4);
            blocked <= (blocked | block_set) & ~(block_clr & ~block_set);
        end
    end
endmodule

module thread_fetch_scheduler #(
    parameter int                XLEN        = 32,
    parameter int                NUM_THREADS = 8,
    parameter int                TID_WIDTH   = 3,
    parameter logic [XLEN-1:0]   RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic [NUM_THREADS-1:0] thread_en_i,
    input  logic [NUM_THREADS-1:0] block_set_i,
    input  logic [NUM_THREADS-1:0] block_clr_i,
    input  logic                   redirect_valid_i,
    input  logic [TID_WIDTH-1:0]   redirect_tid_i,
    input  logic [XLEN-1:0]        redirect_pc_i,
    output logic                   fetch_valid_o,
    output logic [XLEN-1:0]        fetch_pc_o,
    output logic [TID_WIDTH-1:0]   fetch_tid_o,
    output logic                   idle_o
);
    logic [NUM_THREADS-1:0][XLEN-1:0] pc;
    logic [NUM_THREADS-1:0]           eligible;
    logic [NUM_THREADS-1:0]           advance;
    logic [TID_WIDTH-1:0]             last_tid;
    logic [TID_WIDTH-1:0]             win_tid;
    logic                             win_found;
    logic [XLEN-1:0]                  redirect_pc_aligned;

    assign redirect_pc_aligned = {redirect_pc_i[XLEN-1:2], 2'b00};

    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thread
        logic redirect_hit;
        // Out-of-range redirect TIDs match no slot and are dropped here.
        assign redirect_hit = redirect_valid_i && (redirect_tid_i == TID_WIDTH'(t));
        assign advance[t]   = win_found && !stall_i && (win_tid == TID_WIDTH'(t));

        thread_fetch_slot #(
            .XLEN     (XLEN),
            .RESET_PC (RESET_PC)
        ) u_slot (
            .clk          (clk),
            .rst          (rst),
            .thread_en    (thread_en_i[t]),
            .block_set    (block_set_i[t]),
            .block_clr    (block_clr_i[t]),
            .redirect_hit (redirect_hit),
            .redirect_pc  (redirect_pc_aligned),
            .advance      (advance[t]),
            .pc           (pc[t]),
            .eligible     (eligible[t])
        );
    end

    // Search starts just past last_tid and visits last_tid itself last.
    always_comb begin
        logic [TID_WIDTH:0]   sum;
        logic [TID_WIDTH-1:0] idx;
        win_found = 1'b0;
        win_tid   = '0;
        sum       = '0;
        idx       = '0;
        for (int k = 1; k <= NUM_THREADS; k++) begin
            sum = {1'b0, last_tid} + (TID_WIDTH+1)'(k);
            if (sum >= (TID_WIDTH+1)'(NUM_THREADS))
                sum = sum - (TID_WIDTH+1)'(NUM_THREADS);
            idx = sum[TID_WIDTH-1:0];
            if (!win_found && eligible[idx]) begin
                win_found = 1'b1;
                win_tid   = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_valid_o <= 1'b0;
            fetch_pc_o    <= '0;
            fetch_tid_o   <= '0;
            idle_o        <= 1'b1;
            last_tid      <= TID_WIDTH'(NUM_THREADS - 1);
        end else if (!stall_i) begin
            if (win_found) begin
                fetch_valid_o <= 1'b1;
                fetch_pc_o    <= pc[win_tid];
                fetch_tid_o   <= win_tid;
                last_tid      <= win_tid;
                idle_o        <= 1'b0;
            end else begin
                fetch_valid_o <= 1'b0;
                idle_o        <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_thread_fetch_scheduler.sv
// Directed bench for thread_fetch_scheduler: hand-computed issue sequences for
// round-robin, block/unblock, stall, redirect, all-blocked idle and PC wrap.

module tb_thread_fetch_scheduler;
    localparam int XLEN = 32;
    localparam int N    = 8;
    localparam int TW   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall_i;
    logic [N-1:0]  thread_en_i, block_set_i, block_clr_i;
    logic          redirect_valid_i;
    logic [TW-1:0] redirect_tid_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic          fetch_valid_o;
    logic [XLEN-1:0] fetch_pc_o;
    logic [TW-1:0] fetch_tid_o;
    logic          idle_o;

    int checks   = 0;
    int failures = 0;

    thread_fetch_scheduler #(
        .XLEN(XLEN), .NUM_THREADS(N), .TID_WIDTH(TW), .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .thread_en_i(thread_en_i), .block_set_i(block_set_i), .block_clr_i(block_clr_i),
        .redirect_valid_i(redirect_valid_i), .redirect_tid_i(redirect_tid_i),
        .redirect_pc_i(redirect_pc_i),
        .fetch_valid_o(fetch_valid_o), .fetch_pc_o(fetch_pc_o),
        .fetch_tid_o(fetch_tid_o), .idle_o(idle_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_issue(input string tag, input int tid, input logic [31:0] pc);
        chk({tag, ".valid"}, 32'(fetch_valid_o), 32'd1);
        chk({tag, ".tid"},   32'(fetch_tid_o),   32'(tid));
        chk({tag, ".pc"},    fetch_pc_o,         pc);
        chk({tag, ".idle"},  32'(idle_o),        32'd0);
    endtask

    task automatic expect_none(input string tag, input int tid, input logic [31:0] pc);
        chk({tag, ".valid"}, 32'(fetch_valid_o), 32'd0);
        chk({tag, ".tid"},   32'(fetch_tid_o),   32'(tid));
        chk({tag, ".pc"},    fetch_pc_o,         pc);
        chk({tag, ".idle"},  32'(idle_o),        32'd1);
    endtask

    task automatic do_reset(input logic [N-1:0] en);
        rst = 1'b1; stall_i = 1'b0; thread_en_i = en;
        block_set_i = '0; block_clr_i = '0;
        redirect_valid_i = 1'b0; redirect_tid_i = '0; redirect_pc_i = '0;
        tick;
        expect_none("reset", 0, 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        // all eight threads round-robin
        do_reset(8'hFF);
        for (int i = 0; i < 9; i++) begin
            tick;
            expect_issue($sformatf("rr%0d", i), i % 8, (i < 8) ? 32'h0 : 32'h4);
        end

        // two threads, then block/unblock thread 2
        do_reset(8'b0000_0101);
        tick; expect_issue("alt0", 0, 32'h0);
        tick; expect_issue("alt1", 2, 32'h0);
        tick; expect_issue("alt2", 0, 32'h4);
        tick; expect_issue("alt3", 2, 32'h4);
        block_set_i = 8'b0000_0100;
        tick; expect_issue("blk0", 0, 32'h8);
        block_set_i = '0;
        tick; expect_issue("blk1", 0, 32'hC);
        tick; expect_issue("blk2", 0, 32'h10);
        block_clr_i = 8'b0000_0100;
        tick; expect_issue("clr0", 0, 32'h14);
        block_clr_i = '0;
        tick; expect_issue("clr1", 2, 32'h8);
        tick; expect_issue("clr2", 0, 32'h18);

        // stall freezes outputs, then round-robin resumes without skipping PCs
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            expect_issue($sformatf("stall%0d", i), 0, 32'h18);
        end
        stall_i = 1'b0;
        tick; expect_issue("unstall0", 2, 32'hC);
        tick; expect_issue("unstall1", 0, 32'h1C);

        // redirect tid 1 while it would win: skipped, resumes at aligned PC
        do_reset(8'hFF);
        tick; expect_issue("rd_pre", 0, 32'h0);
        redirect_valid_i = 1'b1; redirect_tid_i = 3'd1; redirect_pc_i = 32'h0000_1002;
        tick; expect_issue("rd_skip", 2, 32'h0);
        redirect_valid_i = 1'b0;
        for (int t = 3; t < 8; t++) begin
            tick; expect_issue($sformatf("rd_a%0d", t), t, 32'h0);
        end
        tick; expect_issue("rd_a0", 0, 32'h4);
        tick; expect_issue("rd_new", 1, 32'h0000_1000);
        for (int t = 2; t < 8; t++) begin
            tick; expect_issue($sformatf("rd_b%0d", t), t, 32'h4);
        end
        tick; expect_issue("rd_b0", 0, 32'h8);
        tick; expect_issue("rd_next", 1, 32'h0000_1004);

        // set+clear together keeps thread 3 blocked; all blocked -> idle, outputs hold
        do_reset(8'hFF);
        tick; expect_issue("ab0", 0, 32'h0);
        tick; expect_issue("ab1", 1, 32'h0);
        block_set_i = 8'hFF; block_clr_i = 8'b0000_1000;
        tick; expect_none("ab_set", 1, 32'h0);
        block_set_i = '0; block_clr_i = '0;
        tick; expect_none("ab_hold", 1, 32'h0);
        block_clr_i = 8'b1111_0111;
        tick; expect_none("ab_clr", 1, 32'h0);
        block_clr_i = '0;
        tick; expect_issue("ab_res2", 2, 32'h0);
        tick; expect_issue("ab_res4", 4, 32'h0);

        // reset during stall with pc[0] at the top of the address space
        do_reset(8'b0000_0001);
        redirect_valid_i = 1'b1; redirect_tid_i = 3'd0; redirect_pc_i = 32'hFFFF_FFFF;
        tick; expect_none("wr_rd", 0, 32'h0);
        redirect_valid_i = 1'b0; stall_i = 1'b1;
        tick; expect_none("wr_stall", 0, 32'h0);
        rst = 1'b1;
        tick; expect_none("wr_rst", 0, 32'h0);
        rst = 1'b0; stall_i = 1'b0;
        tick; expect_issue("wr_after_rst", 0, 32'h0);

        // no reset: 0xFFFF_FFFC issues, then wraps to 0
        redirect_valid_i = 1'b1; redirect_tid_i = 3'd0; redirect_pc_i = 32'hFFFF_FFFC;
        tick; expect_none("wrap_rd", 0, 32'h0);
        redirect_valid_i = 1'b0;
        tick; expect_issue("wrap_top", 0, 32'hFFFF_FFFC);
        tick; expect_issue("wrap_zero", 0, 32'h0);
        tick; expect_issue("wrap_four", 0, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
